// File: rtl/regfile_copy_sequencer.sv
// regfile_copy_sequencer
// Turns one block-copy descriptor (src, dst, len) into a series of single-word
// copy transactions on the register file's internal copy port. Each word is
// requested with a one-cycle copy_start and must be acknowledged with a
// one-cycle copy_done before the next word is issued.
//
// Handshakes:
//   cmd  : a descriptor is taken on a rising edge where cmd_valid && cmd_ready.
//          cmd_ready is high exactly while the FSM is IDLE.
//   copy : copy_start is a one-cycle request (state ISSUE). copy_done is only
//          sampled in WAIT; pulses seen in any other state are dropped.
module regfile_copy_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr_src,
    output logic [ADDR_W-1:0] addr_dst,
    output logic              copy_start,
    input  logic              copy_done,
    output logic [1:0]        dbg_state
);

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  remaining;
    logic [TIMER_W-1:0] timer;

    assign dbg_state = state;

    // State register; reset drops any command in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs; abort beats copy_done, copy_done beats timeout.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        copy_start = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                copy_start = 1'b1;
                state_nxt  = abort ? FINISH : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = FINISH;
                end else if (copy_done) begin
                    state_nxt = (remaining == ADDR_W'(1)) ? FINISH : ISSUE;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch descriptor, step addresses per acknowledged word, run the
    // per-word wait timer and record how the command ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_src  <= '0;
            addr_dst  <= '0;
            remaining <= '0;
            timer     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_src  <= cmd_src;
                        addr_dst  <= cmd_dst;
                        remaining <= cmd_len;
                        err       <= 1'b0;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    if (abort) begin
                        err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        err <= 1'b1;
                    end else if (copy_done) begin
                        if (remaining == ADDR_W'(1)) begin
                            err <= 1'b0;
                        end else begin
                            // Addresses wrap naturally at 2^ADDR_W.
                            remaining <= remaining - ADDR_W'(1);
                            addr_src  <= addr_src + ADDR_W'(1);
                            addr_dst  <= addr_dst + ADDR_W'(1);
                        end
                    end else if (timer == TIMER_LAST) begin
                        err <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_copy_sequencer.sv
// Testbench for regfile_copy_sequencer: table of descriptors with hand-computed
// completion timing, a register-file responder with per-word reply gaps, and a
// scoreboard of expected (src, dst) pairs checked on every copy_start.
module tb_regfile_copy_sequencer;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] addr_src;
  logic [ADDR_W-1:0] addr_dst;
  logic              copy_start;
  logic              copy_done = 1'b0;
  logic [1:0]        dbg_state;

  regfile_copy_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .addr_src   (addr_src),
    .addr_dst   (addr_dst),
    .copy_start (copy_start),
    .copy_done  (copy_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [2*ADDR_W-1:0] exp_q[$];

  int gap_tab[16];
  int pend = 0;
  int word_idx = 0;
  int start_total = 0;
  int done_cnt = 0;
  bit prev_start = 1'b0;
  bit spur_req = 1'b0;
  bit spur_on_issue = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    int gap;
    int stall_word;
    int stall_gap;
    int abort_off;
    int exp_starts;
    int exp_err;
    int exp_done_off;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: observe DUT outputs at the falling edge, check copy_start
  // against the scoreboard, and drive the responder's copy_done.
  task automatic tick();
    bit fire;
    @(negedge clk);
    fire = 1'b0;
    if (pend > 0) begin
      pend--;
      fire = (pend == 0);
    end
    if (copy_start) begin
      chk("start_not_back_to_back", 32'(prev_start), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start: got src=%h dst=%h, expected no copy_start (cycle %0d)",
                 addr_src, addr_dst, cyc);
      end else begin
        chk("start_pair", 32'({addr_src, addr_dst}), 32'(exp_q.pop_front()));
      end
      pend = (word_idx < 16) ? gap_tab[word_idx] + 1 : 1;
      word_idx++;
      start_total++;
    end
    prev_start = copy_start;
    if (done) done_cnt++;
    copy_done = fire | spur_req | (copy_start & spur_on_issue);
    spur_req = 1'b0;
  endtask

  // Apply one table vector and check its completion, then idle with stray
  // copy_done / abort to confirm nothing restarts and err holds.
  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    int starts0;
    int done_cyc;
    bit got;
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] d;
    for (int i = 0; i < 16; i++) gap_tab[i] = (i == v.stall_word) ? v.stall_gap : v.gap;
    word_idx = 0;
    s = v.src;
    d = v.dst;
    for (int i = 0; i < v.exp_starts; i++) begin
      exp_q.push_back({s, d});
      s = s + 1'b1;
      d = d + 1'b1;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_src = v.src;
    cmd_dst = v.dst;
    cmd_len = v.len;
    cmd_valid = 1'b1;
    t0 = cyc;
    starts0 = start_total;
    got = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      tick();
      cmd_valid = 1'b0;
      abort = (v.abort_off != 0) && (cyc == t0 + v.abort_off);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
      end
    end
    abort = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_done_cycle"}, done_cyc - t0, v.exp_done_off);
    chk({tag, "_err"}, 32'(err), v.exp_err);
    chk({tag, "_starts"}, start_total - starts0, v.exp_starts);
    chk({tag, "_busy_at_done"}, 32'(busy), 1);
    tick();
    chk({tag, "_ready_after"}, 32'(cmd_ready), 1);
    chk({tag, "_done_one_pulse"}, 32'(done), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      spur_req = (k == 3);
      abort = (k == 6);
    end
    abort = 1'b0;
    chk({tag, "_err_hold"}, 32'(err), v.exp_err);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int d1;
    int d2;
    int dcount;
    int off1;
    int off2;
    int starts0;
    int dones0;

    //            src     dst     len   gap stw sgap ab  st err off
    vecs[0] = '{9'h010, 9'h100, 9'd3, 0, -1, 0,  0, 3, 0, 7};   // basic 3 words
    vecs[1] = '{9'h1FE, 9'h000, 9'd4, 0, -1, 0,  0, 4, 0, 9};   // src wraps 1FF->000
    vecs[2] = '{9'h055, 9'h0AA, 9'd0, 0, -1, 0,  0, 0, 0, 1};   // len 0
    vecs[3] = '{9'h020, 9'h040, 9'd5, 0,  1, 12, 0, 2, 1, 12};  // timeout word 2, late reply
    vecs[4] = '{9'h030, 9'h080, 9'd4, 0, -1, 0,  2, 1, 1, 3};   // abort with copy_done
    vecs[5] = '{9'h060, 9'h070, 9'd2, 7, -1, 0,  0, 2, 0, 19};  // reply on last WAIT cycle
    vecs[6] = '{9'h1FF, 9'h1FD, 9'd3, 3, -1, 0,  0, 3, 0, 16};  // both wrap, gap 3
    vecs[7] = '{9'h0A0, 9'h0B0, 9'd3, 0, -1, 0,  1, 1, 1, 2};   // abort in ISSUE
    vecs[8] = '{9'h0C0, 9'h0D0, 9'd1, 2, -1, 0,  0, 1, 0, 5};   // single word, err cleared

    for (int i = 0; i < 16; i++) gap_tab[i] = 0;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_copy_start", 32'(copy_start), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr_src", 32'(addr_src), 0);
    chk("rst_addr_dst", 32'(addr_dst), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a command: one word issued, no done afterwards.
    for (int i = 0; i < 16; i++) gap_tab[i] = 2;
    word_idx = 0;
    exp_q.push_back({9'h0A0, 9'h0C0});
    cmd_src = 9'h0A0;
    cmd_dst = 9'h0C0;
    cmd_len = 9'd4;
    cmd_valid = 1'b1;
    t0 = cyc;
    starts0 = start_total;
    dones0 = done_cnt;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_copy_start", 32'(copy_start), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 1);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_addr_src", 32'(addr_src), 0);
    chk("midrst_addr_dst", 32'(addr_dst), 0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst_starts", start_total - starts0, 1);
    chk("midrst_no_done", done_cnt - dones0, 0);
    chk("midrst_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Back-to-back commands with cmd_valid held, random reply gaps and a
    // stray copy_done during every ISSUE cycle.
    for (int i = 0; i < 5; i++) gap_tab[i] = $urandom_range(0, 6);
    off1 = 1;
    for (int i = 0; i < 3; i++) off1 += gap_tab[i] + 2;
    off2 = 1;
    for (int i = 3; i < 5; i++) off2 += gap_tab[i] + 2;
    exp_q.push_back({9'h0F0, 9'h1F0});
    exp_q.push_back({9'h0F1, 9'h1F1});
    exp_q.push_back({9'h0F2, 9'h1F2});
    exp_q.push_back({9'h1FF, 9'h000});
    exp_q.push_back({9'h000, 9'h001});
    word_idx = 0;
    spur_on_issue = 1'b1;
    starts0 = start_total;
    cmd_src = 9'h0F0;
    cmd_dst = 9'h1F0;
    cmd_len = 9'd3;
    cmd_valid = 1'b1;
    t0 = cyc;
    d1 = 0;
    d2 = 0;
    dcount = 0;
    for (int k = 0; k < 300 && dcount < 2; k++) begin
      tick();
      if (cyc == t0 + 1) begin
        cmd_src = 9'h1FF;
        cmd_dst = 9'h000;
        cmd_len = 9'd2;
      end
      if (done) begin
        dcount++;
        if (dcount == 1) d1 = cyc;
        else d2 = cyc;
      end
      if (dcount >= 1 && cyc >= d1 + 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    spur_on_issue = 1'b0;
    chk("b2b_done_count", dcount, 2);
    chk("b2b_done1_cycle", d1 - t0, off1);
    chk("b2b_done2_cycle", d2 - d1, off2 + 1);
    chk("b2b_err", 32'(err), 0);
    repeat (16) tick();
    chk("b2b_starts", start_total - starts0, 5);
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("b2b_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_copy_sequencer.md
# regfile_copy_sequencer

Block-copy initiator for the NPU register file's internal copy port. Takes one descriptor (source base, destination base, word count) from the control path. Breaks it into single-word copy transactions on the register file's `addr_src` / `addr_dst` / `copy_start` / `copy_done` handshake, waiting for each completion before issuing the next. Sits between the instruction decoder and `register_file`, so the decoder can move whole tensors (e.g. attention output into a StMM input window) with one command.

## Interface
- `ADDR_W`, 9: register file address width; also the width of the length field.
- `TIMEOUT`, 255: maximum cycles spent waiting for `copy_done` on one word (≥2).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  descriptor present.
- `cmd_ready`  out  1  sequencer can accept a descriptor (= state IDLE).
- `cmd_src`  in  ADDR_W  first source word address.
- `cmd_dst`  in  ADDR_W  first destination word address.
- `cmd_len`  in  ADDR_W  words to copy (0 legal).
- `abort`  in  1  terminate current command.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  last command ended by timeout or abort; valid from `done` onward.
- `addr_src`  out  ADDR_W  to register file, current source address.
- `addr_dst`  out  ADDR_W  to register file, current destination address.
- `copy_start`  out  1  to register file, one-cycle request per word.
- `copy_done`  in  1  from register file, one-cycle completion per word.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH. Registers: state, `addr_src`, `addr_dst`, remaining (ADDR_W), timer (⌈log2 TIMEOUT⌉), `err`.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid`: latch src/dst into `addr_src`/`addr_dst` and len into remaining; clear `err`.
  - Next state: FINISH if len==0, else ISSUE.
- ISSUE: `copy_start`=1 (Moore, exactly one cycle); timer←0; next state WAIT.
- WAIT: `copy_start`=0.
  - `copy_done`=1 and remaining==1 → FINISH, `err`=0.
  - `copy_done`=1 and remaining>1 → remaining−1; `addr_src`+1 and `addr_dst`+1, both mod 2^ADDR_W (wrap 511→0 at ADDR_W=9); → ISSUE.
  - No `copy_done` and timer==TIMEOUT−1 → FINISH with `err`←1.
  - Otherwise timer+1.
- FINISH: `done`=1 for one cycle; → IDLE.
- Addresses ascend. Overlapping src/dst ranges are copied forward with no hazard handling; the caller avoids dst>src overlap.
- `copy_done` is sampled only in WAIT. A `copy_done` seen in IDLE, ISSUE or FINISH is ignored.
- `abort` in ISSUE or WAIT → FINISH with `err`←1 at the next edge; the in-flight word's `copy_done` is ignored. `abort` in IDLE/FINISH is ignored. `abort` takes priority over `copy_done` in the same cycle. A `copy_start` already asserted that cycle is not retracted.
- `cmd_valid` outside IDLE is not accepted; descriptor inputs are don't-care there.

## Timing
- Reset values: state IDLE, `addr_src`=`addr_dst`=0, remaining=0, timer=0, `err`=0. Outputs under reset: `copy_start`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- Reset mid-command: immediate return to IDLE, no `done` pulse, no further `copy_start`.
- Command accepted at edge T:
  - First `copy_start` in cycle T+1.
  - With `copy_done` on the first WAIT cycle, word k's `copy_start` is in cycle T+2k−1 and `done` in cycle T+2N+1.
  - `cmd_ready` reasserts in cycle T+2N+2.
- len=0: `done` in cycle T+1, no `copy_start`, `err`=0.
- Throughput: one word per 2 cycles minimum; `copy_start` is never asserted in consecutive cycles.
- Timeout: WAIT lasts at most TIMEOUT cycles. `copy_done` on the TIMEOUT-th WAIT cycle counts as success.
- `err` holds its value after `done` until the next accepted command.

## Test plan
- src=0x010, dst=0x100, len=3, responder returns `copy_done` one cycle after each `copy_start` → `copy_start` in T+1/T+3/T+5 with pairs (0x010,0x100), (0x011,0x101), (0x012,0x102); `done` at T+7; `err`=0.
- src=0x1FE, dst=0x000, len=4 (ADDR_W=9) → source addresses 0x1FE, 0x1FF, 0x000, 0x001; dst 0x000–0x003.
- len=0 → `done` one cycle after accept, no `copy_start`, `busy` high for exactly 1 cycle.
- TIMEOUT=8, responder never answers word 2 of len=5 → exactly 2 `copy_start`s; `done` with `err`=1 nine cycles after the second `copy_start`; a late `copy_done` afterwards is ignored.
- `abort` and `copy_done` in the same WAIT cycle of word 1 of len=4 → FINISH, `err`=1, no second `copy_start`. `rst_n` pulsed mid-command → outputs at reset values, no `done`.
- Random gaps 0–6 cycles before `copy_done`, spurious `copy_done` in IDLE/ISSUE, back-to-back commands with `cmd_valid` held high → scoreboard matches the expected address sequence and `done` count.
